memory_access_unit: RTL

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/memory_access_pkg.sv | 9 +
 rtl/memory_access_unit_if.sv | 31 +++
 rtl/memory_lane_align.sv | 27 ++
 rtl/memory_access_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared FSM/op enums and bus tag fields for the memory access unit
package memory_access_pkg;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_ADDR, WR_DATA, WR_WAIT, DONE} state_t;
    typedef enum logic [1:0] {OP_NONE = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2} op_t;
    localparam logic TAG_READ = 1'b0;
    localparam logic TAG_WRITE = 1'b1;
    localparam logic [1:0] TAG_MEMORY = 2'd1;
    localparam logic [1:0] TAG_DATA = 2'd2;
endpackage

// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: upstream op, writeback and memory bus signals of the memory access unit
interface memory_access_unit_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int TAG_W = 13,
    parameter int SB_W = 256
);
    logic in_valid, in_ready, in_signed;
    logic [1:0] in_op, in_size;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [SB_W-1:0] in_sb;
    logic out_valid, out_ready, out_err;
    logic [DATA_W-1:0] out_rdata;
    logic [SB_W-1:0] out_sb;
    logic [DATA_W-1:0] bus_req, bus_resp;
    logic [TAG_W-1:0] bus_reqtag;
    logic bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    modport slave (
        input in_valid, in_op, in_size, in_signed, in_addr, in_wdata, in_sb, out_ready,
              bus_reqack, bus_resp, bus_respcyc,
        output in_ready, out_valid, out_rdata, out_sb, out_err, bus_req, bus_reqtag, bus_reqcyc,
               bus_respack
    );
    modport master (
        output in_valid, in_op, in_size, in_signed, in_addr, in_wdata, in_sb, out_ready,
               bus_reqack, bus_resp, bus_respcyc,
        input in_ready, out_valid, out_rdata, out_sb, out_err, bus_req, bus_reqtag, bus_reqcyc,
              bus_respack
    );
endinterface

// File: rtl/memory_lane_align.sv
// memory_lane_align: byte-lane extract/extend for loads and byte merge for sub-word stores
module memory_lane_align #(
    parameter int DATA_W = 64,
    parameter int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_ext,
    output logic [DATA_W-1:0] o_merge
);
    logic [OFF_W+2:0] w_sh;
    logic [6:0] w_nbits;
    logic [DATA_W-1:0] w_shift, w_lmask, w_bmask;
    logic w_sign;
    assign w_sh = {i_off, 3'b000};
    assign w_nbits = 7'd8 << i_size;
    // a shift by the full width yields zero, so the full-word mask comes out all ones
    assign w_lmask = ~({DATA_W{1'b1}} << w_nbits);
    assign w_shift = i_word >> w_sh;
    assign w_sign = i_signed && |(w_shift & w_lmask & ~(w_lmask >> 1));
    assign o_ext = (w_shift & w_lmask) | ({DATA_W{w_sign}} & ~w_lmask);
    assign w_bmask = w_lmask << w_sh;
    assign o_merge = (i_word & ~w_bmask) | ((i_wdata << w_sh) & w_bmask);
endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store sequencer over a tagged request/response memory bus
module memory_access_unit
    import memory_access_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int TAG_W = 13,
    parameter int SB_W = 256,
    parameter int TIMEOUT = 1023
) (
    input logic clk,
    input logic reset,
    memory_access_unit_if.slave io
);
    localparam int NB = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t r_state, w_next, w_rd_next;
    op_t r_op;
    logic [1:0] r_size;
    logic r_signed, r_err, r_respack;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_word, r_rdata, w_ext, w_merge, w_aaddr;
    logic [SB_W-1:0] r_sb;
    logic [CW-1:0] r_cnt;
    logic [3:0] w_bytes;
    logic [TAG_W-1:0] w_tag_rd, w_tag_wr;
    logic w_acc, w_mis, w_full, w_mem_op, w_bus, w_to, w_cap, w_load;
    assign w_bytes = 4'd1 << io.in_size;
    assign w_mis = (|(io.in_addr[OFF_W-1:0] & OFF_W'(w_bytes - 4'd1))) || (int'(w_bytes) > NB);
    assign w_full = int'(w_bytes) == NB;
    assign w_mem_op = io.in_op == OP_LOAD || io.in_op == OP_STORE;
    assign w_acc = io.in_valid && r_state == IDLE;
    assign w_bus = r_state inside {RD_REQ, RD_WAIT, WR_ADDR, WR_DATA, WR_WAIT};
    assign w_to = w_bus && r_cnt == CW'(TIMEOUT);
    // an ack and response in the same RD_REQ cycle is a complete read
    assign w_cap = !w_to && io.bus_respcyc &&
                   (r_state == RD_WAIT || r_state == WR_WAIT || (r_state == RD_REQ && io.bus_reqack));
    assign w_load = r_op == OP_LOAD;
    assign w_rd_next = w_load ? DONE : WR_ADDR;
    assign w_aaddr = DATA_W'({r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
    assign w_tag_rd = {TAG_READ, TAG_MEMORY, TAG_DATA, {(TAG_W-5){1'b0}}};
    assign w_tag_wr = {TAG_WRITE, TAG_MEMORY, TAG_DATA, {(TAG_W-5){1'b0}}};
    assign io.out_rdata = r_rdata;
    assign io.out_sb = r_sb;
    assign io.out_err = r_err;
    assign io.bus_respack = r_respack;
    memory_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_word(io.bus_resp), .i_wdata(r_word), .i_off(r_addr[OFF_W-1:0]), .i_size(r_size),
        .i_signed(r_signed), .o_ext(w_ext), .o_merge(w_merge)
    );
    always_comb begin
        w_next = r_state;
        io.in_ready = 1'b0;
        io.out_valid = 1'b0;
        io.bus_reqcyc = 1'b0;
        io.bus_req = '0;
        io.bus_reqtag = '0;
        case (r_state)
            IDLE: begin
                io.in_ready = 1'b1;
                if (io.in_valid)
                    w_next = (!w_mem_op || w_mis) ? DONE :
                             (io.in_op == OP_STORE && w_full) ? WR_ADDR : RD_REQ;
            end
            RD_REQ: begin
                io.bus_reqcyc = !w_to;
                io.bus_req = w_aaddr;
                io.bus_reqtag = w_tag_rd;
                w_next = w_to ? DONE : w_cap ? w_rd_next : io.bus_reqack ? RD_WAIT : RD_REQ;
            end
            RD_WAIT: w_next = w_to ? DONE : w_cap ? w_rd_next : RD_WAIT;
            WR_ADDR: begin
                io.bus_reqcyc = !w_to;
                io.bus_req = w_aaddr;
                io.bus_reqtag = w_tag_wr;
                w_next = w_to ? DONE : io.bus_reqack ? WR_DATA : WR_ADDR;
            end
            WR_DATA: begin
                io.bus_reqcyc = !w_to;
                io.bus_req = r_word;
                io.bus_reqtag = w_tag_wr;
                w_next = w_to ? DONE : io.bus_reqack ? WR_WAIT : WR_DATA;
            end
            WR_WAIT: w_next = (w_to || w_cap) ? DONE : WR_WAIT;
            DONE: begin
                io.out_valid = 1'b1;
                w_next = io.out_ready ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_cnt <= (w_next != r_state) ? '0 : (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
        end
    end
    // r_word holds store data until a sub-word read returns, then the merged write word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op <= OP_NONE;
            r_size <= '0;
            r_signed <= 1'b0;
            r_addr <= '0;
            r_word <= '0;
            r_sb <= '0;
            r_rdata <= '0;
            r_err <= 1'b0;
            r_respack <= 1'b0;
        end else begin
            r_respack <= w_cap;
            if (w_acc) begin
                r_op <= op_t'(io.in_op);
                r_size <= io.in_size;
                r_signed <= io.in_signed;
                r_addr <= io.in_addr;
                r_word <= io.in_wdata;
                r_sb <= io.in_sb;
                r_rdata <= '0;
                r_err <= w_mem_op && w_mis;
            end
            if (w_cap && w_load) r_rdata <= w_ext;
            if (w_cap && !w_load && r_state != WR_WAIT) r_word <= w_merge;
            if (w_to) r_err <= 1'b1;
        end
    end
endmodule
